// File: rtl/ac_codeword_bit_packer_if.sv
// Handshake bundle between the AC entropy encoder, the bit packer and the
// downstream slice/bitstream assembler.
interface ac_codeword_bit_packer_if #(
    parameter int LEN_W = 6,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_code;
    logic [LEN_W-1:0] in_len;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_word;
    logic             out_last;
    logic             flush_done;
    logic [CNT_W-1:0] word_count;

    // Encoder/downstream side: drives codewords, flush and out_ready.
    modport master (
        output in_valid, in_code, in_len, flush, out_ready,
        input  in_ready, out_valid, out_word, out_last, flush_done, word_count
    );

    // Packer side.
    modport slave (
        input  in_valid, in_code, in_len, flush, out_ready,
        output in_ready, out_valid, out_word, out_last, flush_done, word_count
    );
endinterface

// File: rtl/ac_codeword_bit_packer.sv
// Packs variable-length AC codewords MSB-first into 32-bit words. A 64-bit
// left-aligned accumulator holds up to two words; the top half is always the
// word on offer. A flush pads the tail word and ends the slice.
module ac_codeword_bit_packer #(
    parameter int LEN_W   = 6,
    parameter int CNT_W   = 16,
    parameter bit PAD_BIT = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    ac_codeword_bit_packer_if.slave bus
);
    typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

    state_t           state_q, state_d;
    logic [63:0]      acc_q, acc_d;
    logic [6:0]       fill_q, fill_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [CNT_W-1:0] wc_q, wc_d;

    logic             accept, emit, flushing;
    logic [6:0]       len_eff;
    logic [31:0]      code_m;
    logic [63:0]      acc_s;
    logic [6:0]       fill_s;
    logic [31:0]      pad_mask;

    assign bus.in_ready   = (state_q == RUN) && (fill_q <= 7'd32);
    assign accept         = bus.in_valid && bus.in_ready;
    assign emit           = out_valid_q && bus.out_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_word   = acc_q[63:32];
    assign bus.out_last   = out_last_q;
    assign bus.flush_done = (state_q == DONE);
    assign bus.word_count = wc_q;

    // Clamp illegal lengths to 32 and drop code bits above the length.
    always_comb begin
        len_eff = 7'd32;
        if (bus.in_len <= LEN_W'(32))
            len_eff = 7'(bus.in_len);
        code_m = bus.in_code;
        if (len_eff != 7'd32)
            code_m = bus.in_code & ((32'h1 << len_eff) - 32'h1);
    end

    // Next state: emit shift first, then append, then flush padding/termination.
    always_comb begin
        state_d     = state_q;
        wc_d        = wc_q;
        acc_s       = emit ? {acc_q[31:0], 32'h0} : acc_q;
        fill_s      = emit ? (fill_q - 7'd32) : fill_q;
        acc_d       = acc_s;
        fill_d      = fill_s;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        flushing    = 1'b0;
        pad_mask    = 32'h0;

        if (emit)
            wc_d = wc_q + CNT_W'(1);

        case (state_q)
            RUN: begin
                if (accept) begin
                    // Codeword MSB lands at bit 63-fill_s; a zero shift-in of 64 is harmless.
                    acc_d  = acc_s | ({32'h0, code_m} << (7'd64 - fill_s - len_eff));
                    fill_d = fill_s + len_eff;
                end
                if (bus.flush)
                    state_d = FLUSH;
            end
            FLUSH: ;
            DONE: begin
                acc_d   = 64'h0;
                fill_d  = 7'd0;
                wc_d    = '0;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase

        // Entering or staying in FLUSH: pad a partial tail straight away so the
        // final word is offered on the next cycle; nothing left means done.
        flushing = (state_d == FLUSH);
        if (flushing) begin
            if (fill_d == 7'd0) begin
                state_d = DONE;
            end else if (fill_d < 7'd32) begin
                pad_mask = 32'hFFFF_FFFF >> fill_d;
                if (PAD_BIT)
                    acc_d[63:32] = acc_d[63:32] | pad_mask;
                else
                    acc_d[63:32] = acc_d[63:32] & ~pad_mask;
                fill_d = 7'd32;
            end
        end

        out_valid_d = (fill_d >= 7'd32);
        // Exactly one word left during a flush means it is the slice's last word.
        out_last_d  = flushing && (fill_d == 7'd32);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            acc_q       <= 64'h0;
            fill_q      <= 7'd0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            wc_q        <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            wc_q        <= wc_d;
        end
    end
endmodule

// File: tb/tb_ac_codeword_bit_packer.sv
// Bench for ac_codeword_bit_packer: a bit-queue model of the packed stream,
// directed spec scenarios with literal expectations, then random traffic.
module tb_ac_codeword_bit_packer;
    localparam bit PAD = 1'b0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ac_codeword_bit_packer_if #(.LEN_W(6), .CNT_W(16)) bus ();

    ac_codeword_bit_packer #(.LEN_W(6), .CNT_W(16), .PAD_BIT(PAD)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    // model state
    bit          mbuf[$];
    logic [31:0] exw[$];
    logic        exl[$];
    logic [15:0] mwc = '0;
    bit          busy = 1'b0;
    int          n_flush = 0;
    int          n_done = 0;
    logic [15:0] wc_at_done = '0;
    logic [31:0] seen_w[$];
    logic        seen_l[$];
    bit          stall_prev = 1'b0;
    bit          fl_prev = 1'b0;
    logic [31:0] prev_word = '0;
    logic        prev_last = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: dut=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void take_word(input logic l);
        logic [31:0] w = '0;
        for (int i = 0; i < 32; i++) w = {w[30:0], mbuf.pop_front()};
        exw.push_back(w);
        exl.push_back(l);
    endfunction

    // Model + single compare process, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            mbuf.delete(); exw.delete(); exl.delete();
            mwc = '0; busy = 1'b0; stall_prev = 1'b0; fl_prev = 1'b0;
            n_flush = n_done;
        end else begin
            chk("out_valid", bus.out_valid, exw.size() != 0);
            chk("in_ready", bus.in_ready, !busy && (mbuf.size() + 32 * exw.size() <= 32));
            chk("word_count", bus.word_count, mwc);
            if (stall_prev) begin
                chk("stall_word", bus.out_word, prev_word);
                if (!fl_prev) chk("stall_last", bus.out_last, prev_last);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exw.size() == 0) begin
                    chk("unexpected_word", 1, 0);
                end else begin
                    chk("out_word", bus.out_word, exw.pop_front());
                    chk("out_last", bus.out_last, exl.pop_front());
                end
                seen_w.push_back(bus.out_word);
                seen_l.push_back(bus.out_last);
                mwc++;
            end
            if (bus.in_valid && bus.in_ready) begin
                int len;
                len = (bus.in_len > 6'd32) ? 32 : int'(bus.in_len);
                for (int b = len - 1; b >= 0; b--) mbuf.push_back(bus.in_code[b]);
                while (mbuf.size() >= 32) take_word(1'b0);
            end
            fl_prev = 1'b0;
            if (bus.flush && !busy) begin
                busy = 1'b1; fl_prev = 1'b1; n_flush++;
                if (mbuf.size() != 0) begin
                    while (mbuf.size() < 32) mbuf.push_back(PAD);
                    take_word(1'b1);
                end else if (exw.size() != 0) begin
                    exl[exl.size() - 1] = 1'b1;
                end
            end
            if (bus.flush_done) begin
                chk("done_expected", busy, 1);
                chk("done_drained", exw.size(), 0);
                n_done++;
                wc_at_done = bus.word_count;
                mwc = '0;
                busy = 1'b0;
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            prev_word  = bus.out_word;
            prev_last  = bus.out_last;
        end
    end

    task automatic send(input logic [31:0] c, input logic [5:0] l, input logic f);
        bit ok = 1'b0;
        bus.in_valid = 1'b1; bus.in_code = c; bus.in_len = l; bus.flush = f;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
        end
        chk("send_timeout", ok, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.flush = 1'b0;
    endtask

    task automatic flush_only();
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        @(posedge clk); #1;
    endtask

    initial begin
        int d0;
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_code = '0; bus.in_len = '0;
        bus.flush = 1'b0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_word", bus.out_word, 0);
        @(posedge clk); #1;

        // mid-stream reset with fill=20
        send(32'hABCDE, 6'd20, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_in_ready", bus.in_ready, 1);
        chk("mid_rst_word_count", bus.word_count, 0);
        chk("mid_rst_out_word", bus.out_word, 0);
        @(posedge clk); #1;

        // four bytes -> one word, valid the cycle after the 4th accept
        send(32'hAB, 6'd8, 1'b0); send(32'hCD, 6'd8, 1'b0);
        send(32'hEF, 6'd8, 1'b0); send(32'h12, 6'd8, 1'b0);
        @(negedge clk);
        chk("byte_pack_valid", bus.out_valid, 1);
        chk("byte_pack_word", bus.out_word, 32'hABCDEF12);
        @(posedge clk); #1;

        // flush with fill=0: no word, flush_done one cycle later
        bus.flush = 1'b1;
        @(negedge clk);
        chk("f0_no_done_yet", bus.flush_done, 0);
        @(posedge clk); #1 bus.flush = 1'b0;
        @(negedge clk);
        chk("f0_done", bus.flush_done, 1);
        chk("f0_out_valid", bus.out_valid, 0);
        chk("f0_wc_held", bus.word_count, 1);
        @(negedge clk);
        chk("f0_done_pulse", bus.flush_done, 0);
        chk("f0_wc_clear", bus.word_count, 0);
        @(posedge clk); #1;

        // 20+20 bits then flush
        seen_w.delete(); seen_l.delete(); d0 = n_done;
        send(32'hABCDE, 6'd20, 1'b0); send(32'h12345, 6'd20, 1'b0);
        flush_only();
        settle(6);
        chk("f40_count", seen_w.size(), 2);
        if (seen_w.size() == 2) begin
            chk("f40_w0", seen_w[0], 32'hABCDE123); chk("f40_l0", seen_l[0], 0);
            chk("f40_w1", seen_w[1], 32'h45000000); chk("f40_l1", seen_l[1], 1);
        end
        chk("f40_wc", wc_at_done, 2);
        chk("f40_done", n_done - d0, 1);

        // masking
        seen_w.delete(); seen_l.delete();
        send(32'hFFFFFFF5, 6'd4, 1'b0); send(32'h0, 6'd28, 1'b0);
        settle(3);
        chk("mask_count", seen_w.size(), 1);
        if (seen_w.size() == 1) chk("mask_word", seen_w[0], 32'h50000000);
        flush_only(); settle(4);

        // backpressure with len-32 codes
        seen_w.delete(); seen_l.delete();
        bus.out_ready = 1'b0;
        send(32'h11111111, 6'd32, 1'b0); send(32'h22222222, 6'd32, 1'b0);
        @(negedge clk);
        chk("bp_in_ready", bus.in_ready, 0);
        chk("bp_word", bus.out_word, 32'h11111111);
        repeat (3) @(negedge clk);
        chk("bp_word_held", bus.out_word, 32'h11111111);
        @(posedge clk); #1 bus.out_ready = 1'b1;
        settle(4);
        chk("bp_count", seen_w.size(), 2);
        if (seen_w.size() == 2) begin
            chk("bp_w0", seen_w[0], 32'h11111111);
            chk("bp_w1", seen_w[1], 32'h22222222);
        end
        flush_only(); settle(4);

        // flush with fill=32 (with the code) -> single last word
        seen_w.delete(); seen_l.delete(); d0 = n_done;
        send(32'hDEADBEEF, 6'd32, 1'b1);
        settle(5);
        chk("f32_count", seen_w.size(), 1);
        if (seen_w.size() == 1) begin
            chk("f32_word", seen_w[0], 32'hDEADBEEF); chk("f32_last", seen_l[0], 1);
        end
        chk("f32_done", n_done - d0, 1);

        // flush while a full word is stalled -> that word becomes last
        seen_w.delete(); seen_l.delete();
        bus.out_ready = 1'b0;
        send(32'h13579BDF, 6'd32, 1'b0);
        flush_only();
        @(negedge clk);
        chk("stall_f32_last", bus.out_last, 1);
        @(posedge clk); #1 bus.out_ready = 1'b1;
        settle(4);
        chk("stall_f32_count", seen_w.size(), 1);
        if (seen_w.size() == 1) chk("stall_f32_word", seen_w[0], 32'h13579BDF);

        // illegal length clamps to 32
        seen_w.delete(); seen_l.delete();
        send(32'hFFFFFFFF, 6'd40, 1'b1);
        settle(5);
        chk("len40_count", seen_w.size(), 1);
        if (seen_w.size() == 1) begin
            chk("len40_word", seen_w[0], 32'hFFFFFFFF); chk("len40_last", seen_l[0], 1);
        end

        // random traffic
        for (int cyc = 0; cyc < 4000; cyc++) begin
            int r;
            r = $urandom_range(0, 9);
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.in_code   = $urandom;
            bus.in_len    = (r < 2) ? 6'd32 : 6'($urandom_range(0, 40));
            bus.out_ready = (cyc % 500 < 60) ? 1'b0 : ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 39) == 0);
            reset         = (cyc == 2000 || cyc == 2001);
            @(posedge clk); #1;
        end
        reset = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.flush = 1'b0;
        settle(4);
        flush_only();
        settle(20);
        chk("end_drained", exw.size(), 0);
        chk("end_idle", busy, 0);
        chk("end_flush_vs_done", n_done, n_flush);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
